// File: rtl/pkt_capture_pkg.sv
// Shared types and constants for the packet capture stage: FSM states,
// control-word field layout and small arithmetic helpers.
package pkt_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        ISSUE   = 2'd2,
        WAIT    = 2'd3
    } cap_state_e;

    localparam int CTRL_LEN_LSB   = 0;
    localparam int CTRL_LEN_W     = 16;
    localparam int CTRL_TRUNC_BIT = 16;
    localparam int CTRL_RSVD_LSB  = 17;
    localparam int CTRL_RSVD_W    = 7;
    localparam int CTRL_SEQ_LSB   = 24;
    localparam int CTRL_SEQ_W     = 8;

    function automatic logic [31:0] pack_control(input logic [15:0] len,
                                                 input logic        trunc,
                                                 input logic [7:0]  seq);
        logic [31:0] c;
        c = 32'd0;
        c[CTRL_LEN_LSB +: CTRL_LEN_W] = len;
        c[CTRL_TRUNC_BIT]             = trunc;
        c[CTRL_SEQ_LSB +: CTRL_SEQ_W] = seq;
        return c;
    endfunction

    // Saturating add of a small increment to a 16-bit counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v,
                                              input logic [1:0]  inc);
        logic [16:0] s;
        s = {1'b0, v} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/pkt_capture_if.sv
// Bundle of the stream tap, FIFO write port and write-controller descriptor
// signals. The capture block is the slave; the surrounding fabric is the master.
interface pkt_capture_if;
    logic [31:0] snk_data;
    logic        snk_valid;
    logic        snk_sop;
    logic        snk_eop;
    logic [1:0]  snk_empty;
    logic        snk_ready;
    logic        fifo_full;
    logic        fifo_wr;
    logic [31:0] fifo_in;
    logic        wr_ctrl;
    logic        wr_ctrl_rdy;
    logic [31:0] control;
    logic [31:0] pkt_begin;
    logic [31:0] pkt_end;
    logic [31:0] write_address;
    logic [15:0] drop_count;

    modport slave (
        input  snk_data, snk_valid, snk_sop, snk_eop, snk_empty,
        input  fifo_full, wr_ctrl_rdy,
        output snk_ready, fifo_wr, fifo_in, wr_ctrl,
        output control, pkt_begin, pkt_end, write_address, drop_count
    );

    modport master (
        output snk_data, snk_valid, snk_sop, snk_eop, snk_empty,
        output fifo_full, wr_ctrl_rdy,
        input  snk_ready, fifo_wr, fifo_in, wr_ctrl,
        input  control, pkt_begin, pkt_end, write_address, drop_count
    );
endinterface

// File: rtl/pkt_capture_ring_offset.sv
// Host ring-buffer offset: wraps to zero at packet start when a worst-case
// packet would not fit, and advances by the committed packet size.
module ring_offset #(
    parameter logic [31:0] BUF_SIZE      = 32'h0001_0000,
    parameter logic [15:0] MAX_PKT_WORDS = 16'd512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [15:0] words_i,
    input  logic        commit_i,
    output logic [31:0] begin_o
);

    logic [31:0] offset_q, offset_d;
    logic        wrap_s;

    // Wrap check and next-offset selection.
    always_comb begin
        wrap_s  = ({1'b0, offset_q} + {15'd0, MAX_PKT_WORDS, 2'b00}) > {1'b0, BUF_SIZE};
        begin_o = (start_i && wrap_s) ? 32'd0 : offset_q;
        if (commit_i) begin
            offset_d = offset_q + {14'd0, words_i, 2'b00};
        end else if (start_i) begin
            offset_d = begin_o;
        end else begin
            offset_d = offset_q;
        end
    end

    // Offset register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            offset_q <= 32'd0;
        end else begin
            offset_q <= offset_d;
        end
    end

endmodule

// File: rtl/pkt_capture.sv
// Snoops an Avalon-ST packet stream, copies accepted words into the shared
// FIFO and hands one descriptor per closed packet to the write controller.
module pkt_capture
    import pkt_capture_pkg::*;
#(
    parameter logic [31:0] BUF_BASE      = 32'h0000_0000,
    parameter logic [31:0] BUF_SIZE      = 32'h0001_0000,
    parameter logic [15:0] MAX_PKT_WORDS = 16'd512
) (
    input logic          clk,
    input logic          reset,
    pkt_capture_if.slave bus
);

    cap_state_e  state_q, state_d;
    logic [15:0] words_q, words_d;
    logic        trunc_q, trunc_d;
    logic [7:0]  seq_q, seq_d;
    logic [15:0] drop_q, drop_d;
    logic        fifo_wr_q, fifo_wr_d;
    logic [31:0] fifo_in_q, fifo_in_d;
    logic        wr_ctrl_q, wr_ctrl_d;
    logic [31:0] control_q, control_d;
    logic [31:0] pkt_begin_q, pkt_begin_d;
    logic [31:0] pkt_end_q, pkt_end_d;
    logic [31:0] wr_addr_q, wr_addr_d;

    logic        start_s, commit_s, word_s, issue_s;
    logic [15:0] cur_words_s, words_inc_s, len_full_s, len_word_s;
    logic        cur_trunc_s, wr_ok_s, sop_s;
    logic [15:0] issue_words_s, issue_len_s;
    logic        issue_trunc_s;
    logic [1:0]  drop_inc_s;
    logic [31:0] begin_s;

    ring_offset #(
        .BUF_SIZE      (BUF_SIZE),
        .MAX_PKT_WORDS (MAX_PKT_WORDS)
    ) u_ring (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_s),
        .words_i  (words_q),
        .commit_i (commit_s),
        .begin_o  (begin_s)
    );

    // Next-state, FIFO write and descriptor computation.
    always_comb begin
        start_s       = 1'b0;
        commit_s      = 1'b0;
        word_s        = 1'b0;
        issue_s       = 1'b0;
        drop_inc_s    = 2'd0;
        issue_words_s = words_q;
        issue_len_s   = {words_q[13:0], 2'b00};
        issue_trunc_s = 1'b1;
        state_d       = state_q;
        words_d       = words_q;
        trunc_d       = trunc_q;
        seq_d         = seq_q;
        fifo_wr_d     = 1'b0;
        fifo_in_d     = fifo_in_q;
        wr_ctrl_d     = 1'b0;
        control_d     = control_q;
        pkt_begin_d   = pkt_begin_q;
        pkt_end_d     = pkt_end_q;
        wr_addr_d     = wr_addr_q;

        sop_s       = bus.snk_valid && bus.snk_sop;
        // The sop word taken in IDLE starts from a clean word count.
        cur_words_s = (state_q == IDLE) ? 16'd0 : words_q;
        cur_trunc_s = (state_q == IDLE) ? 1'b0 : trunc_q;
        wr_ok_s     = !cur_trunc_s && !bus.fifo_full && (cur_words_s < MAX_PKT_WORDS);
        words_inc_s = cur_words_s + {15'd0, wr_ok_s};
        len_full_s  = {words_inc_s[13:0], 2'b00};
        len_word_s  = wr_ok_s ? (len_full_s - {14'd0, bus.snk_empty}) : len_full_s;

        case (state_q)
            IDLE: begin
                start_s = sop_s;
                word_s  = sop_s;
            end
            CAPTURE: begin
                if (sop_s) begin
                    trunc_d = 1'b1;
                    if (words_q == 16'd0) begin
                        state_d    = IDLE;
                        drop_inc_s = 2'd2;
                    end else begin
                        issue_s    = 1'b1;
                        drop_inc_s = 2'd1;
                    end
                end else begin
                    word_s = bus.snk_valid;
                end
            end
            ISSUE: begin
                state_d    = WAIT;
                drop_inc_s = {1'b0, sop_s};
            end
            WAIT: begin
                drop_inc_s = {1'b0, sop_s};
                if (bus.wr_ctrl_rdy) begin
                    commit_s = 1'b1;
                    seq_d    = seq_q + 8'd1;
                    words_d  = 16'd0;
                    trunc_d  = 1'b0;
                    state_d  = IDLE;
                end else begin
                    state_d  = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (word_s) begin
            fifo_wr_d = wr_ok_s;
            fifo_in_d = wr_ok_s ? bus.snk_data : fifo_in_q;
            words_d   = words_inc_s;
            trunc_d   = cur_trunc_s | ~wr_ok_s;
            if (bus.snk_eop) begin
                if (words_inc_s == 16'd0) begin
                    state_d    = IDLE;
                    drop_inc_s = 2'd1;
                end else begin
                    issue_s       = 1'b1;
                    issue_words_s = words_inc_s;
                    issue_len_s   = len_word_s;
                    issue_trunc_s = trunc_d;
                end
            end else begin
                state_d = CAPTURE;
            end
        end else begin
            fifo_wr_d = 1'b0;
        end

        if (issue_s) begin
            state_d     = ISSUE;
            wr_ctrl_d   = 1'b1;
            control_d   = pack_control(issue_len_s, issue_trunc_s, seq_q);
            pkt_begin_d = begin_s;
            pkt_end_d   = begin_s + {14'd0, issue_words_s, 2'b00};
            wr_addr_d   = BUF_BASE + begin_s;
        end else begin
            wr_ctrl_d   = 1'b0;
        end

        drop_d = sat_inc16(drop_q, drop_inc_s);
    end

    // FSM and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            words_q     <= 16'd0;
            trunc_q     <= 1'b0;
            seq_q       <= 8'd0;
            drop_q      <= 16'd0;
            fifo_wr_q   <= 1'b0;
            fifo_in_q   <= 32'd0;
            wr_ctrl_q   <= 1'b0;
            control_q   <= 32'd0;
            pkt_begin_q <= 32'd0;
            pkt_end_q   <= 32'd0;
            wr_addr_q   <= BUF_BASE;
        end else begin
            state_q     <= state_d;
            words_q     <= words_d;
            trunc_q     <= trunc_d;
            seq_q       <= seq_d;
            drop_q      <= drop_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_in_q   <= fifo_in_d;
            wr_ctrl_q   <= wr_ctrl_d;
            control_q   <= control_d;
            pkt_begin_q <= pkt_begin_d;
            pkt_end_q   <= pkt_end_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    assign bus.snk_ready     = 1'b1;
    assign bus.fifo_wr       = fifo_wr_q;
    assign bus.fifo_in       = fifo_in_q;
    assign bus.wr_ctrl       = wr_ctrl_q;
    assign bus.control       = control_q;
    assign bus.pkt_begin     = pkt_begin_q;
    assign bus.pkt_end       = pkt_end_q;
    assign bus.write_address = wr_addr_q;
    assign bus.drop_count    = drop_q;

endmodule

// File: tb/tb_pkt_capture.sv
// Directed bench for pkt_capture: small ring (256 B, 16-word cap) at base 0x1000.
module tb_pkt_capture;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;
    int   n_fail;
    int   wr_cnt;
    int   ctrl_cnt;
    int   snap;

    pkt_capture_if bus ();

    pkt_capture #(
        .BUF_BASE      (32'h0000_1000),
        .BUF_SIZE      (32'h0000_0100),
        .MAX_PKT_WORDS (16'd16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.fifo_wr === 1'b1) wr_cnt++;
        if (bus.wr_ctrl === 1'b1) ctrl_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic sop, input logic eop,
                         input logic [1:0] emp, input logic full);
        bus.snk_data  = d;
        bus.snk_valid = 1'b1;
        bus.snk_sop   = sop;
        bus.snk_eop   = eop;
        bus.snk_empty = emp;
        bus.fifo_full = full;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        bus.snk_valid = 1'b0;
        bus.snk_sop   = 1'b0;
        bus.snk_eop   = 1'b0;
        bus.snk_empty = 2'd0;
        bus.fifo_full = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rdy();
        bus.wr_ctrl_rdy = 1'b1;
        idle_cycle();
        bus.wr_ctrl_rdy = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] base, input int n, input logic [1:0] emp);
        for (int i = 0; i < n; i++) begin
            drive(base + 32'(i), (i == 0), (i == n - 1), (i == n - 1) ? emp : 2'd0, 1'b0);
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0; wr_cnt = 0; ctrl_cnt = 0;
        reset           = 1'b0;
        bus.snk_data    = 32'd0;
        bus.snk_valid   = 1'b0;
        bus.snk_sop     = 1'b0;
        bus.snk_eop     = 1'b0;
        bus.snk_empty   = 2'd0;
        bus.fifo_full   = 1'b0;
        bus.wr_ctrl_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, bus.snk_ready}, 32'd1);
        chk("rst_fifo_wr", {31'd0, bus.fifo_wr}, 32'd0);
        chk("rst_fifo_in", bus.fifo_in, 32'd0);
        chk("rst_wr_ctrl", {31'd0, bus.wr_ctrl}, 32'd0);
        chk("rst_control", bus.control, 32'd0);
        chk("rst_end", bus.pkt_end, 32'd0);
        chk("rst_waddr", bus.write_address, 32'h0000_1000);
        chk("rst_drop", {16'd0, bus.drop_count}, 32'd0);
        reset = 1'b1;
        idle_cycle();

        // P1: 3 words, empty=1
        drive(32'hA0, 1'b1, 1'b0, 2'd0, 1'b0);
        chk("p1_w0_wr", {31'd0, bus.fifo_wr}, 32'd1);
        chk("p1_w0_in", bus.fifo_in, 32'hA0);
        chk("p1_w0_noctrl", {31'd0, bus.wr_ctrl}, 32'd0);
        drive(32'hA1, 1'b0, 1'b0, 2'd0, 1'b0);
        drive(32'hA2, 1'b0, 1'b1, 2'd1, 1'b0);
        chk("p1_w2_wr", {31'd0, bus.fifo_wr}, 32'd1);
        chk("p1_w2_in", bus.fifo_in, 32'hA2);
        chk("p1_wr_ctrl", {31'd0, bus.wr_ctrl}, 32'd1);
        chk("p1_control", bus.control, 32'h0000_000B);
        chk("p1_begin", bus.pkt_begin, 32'd0);
        chk("p1_end", bus.pkt_end, 32'd12);
        chk("p1_waddr", bus.write_address, 32'h0000_1000);
        idle_cycle();
        chk("p1_ctrl_pulse", {31'd0, bus.wr_ctrl}, 32'd0);
        chk("p1_hold", bus.control, 32'h0000_000B);
        chk("p1_nwrites", 32'(wr_cnt), 32'd3);
        idle_cycle();
        chk("p1_hold2", bus.pkt_end, 32'd12);
        pulse_rdy();
        snap = wr_cnt;

        // P2: fifo_full on word 3 of 5
        drive(32'hB0, 1'b1, 1'b0, 2'd0, 1'b0);
        drive(32'hB1, 1'b0, 1'b0, 2'd0, 1'b0);
        drive(32'hB2, 1'b0, 1'b0, 2'd0, 1'b1);
        chk("p2_full_nowr", {31'd0, bus.fifo_wr}, 32'd0);
        drive(32'hB3, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("p2_after_trunc_nowr", {31'd0, bus.fifo_wr}, 32'd0);
        drive(32'hB4, 1'b0, 1'b1, 2'd3, 1'b0);
        chk("p2_wr_ctrl", {31'd0, bus.wr_ctrl}, 32'd1);
        chk("p2_control", bus.control, 32'h0101_0008);
        chk("p2_begin", bus.pkt_begin, 32'd12);
        chk("p2_end", bus.pkt_end, 32'd20);
        chk("p2_waddr", bus.write_address, 32'h0000_100C);
        idle_cycle();
        chk("p2_nwrites", 32'(wr_cnt - snap), 32'd2);

        // Single-word packet arriving in WAIT is dropped
        drive(32'hC0, 1'b1, 1'b1, 2'd0, 1'b0);
        chk("wait_drop_nowr", {31'd0, bus.fifo_wr}, 32'd0);
        chk("wait_drop_cnt", {16'd0, bus.drop_count}, 32'd1);
        chk("wait_hold_ctrl", bus.control, 32'h0101_0008);
        chk("wait_hold_begin", bus.pkt_begin, 32'd12);
        idle_cycle();
        pulse_rdy();

        // P3: 17 words against a 16-word cap
        snap = wr_cnt;
        send_pkt(32'hD00, 17, 2'd0);
        chk("p3_last_nowr", {31'd0, bus.fifo_wr}, 32'd0);
        chk("p3_wr_ctrl", {31'd0, bus.wr_ctrl}, 32'd1);
        chk("p3_control", bus.control, 32'h0201_0040);
        chk("p3_begin", bus.pkt_begin, 32'd20);
        chk("p3_end", bus.pkt_end, 32'd84);
        idle_cycle();
        chk("p3_nwrites", 32'(wr_cnt - snap), 32'd16);
        pulse_rdy();

        // P4, P5: fill the ring up to offset 200
        send_pkt(32'hE00, 16, 2'd0);
        chk("p4_control", bus.control, 32'h0300_0040);
        chk("p4_begin", bus.pkt_begin, 32'd84);
        idle_cycle();
        pulse_rdy();
        send_pkt(32'hF00, 13, 2'd0);
        chk("p5_control", bus.control, 32'h0400_0034);
        chk("p5_end", bus.pkt_end, 32'd200);
        idle_cycle();
        pulse_rdy();

        // P6: offset 200 + 64 > 256 forces a wrap
        send_pkt(32'h600, 2, 2'd0);
        chk("p6_control", bus.control, 32'h0500_0008);
        chk("p6_begin", bus.pkt_begin, 32'd0);
        chk("p6_end", bus.pkt_end, 32'd8);
        chk("p6_waddr", bus.write_address, 32'h0000_1000);
        idle_cycle();
        pulse_rdy();

        // Valid word without sop in IDLE is ignored
        drive(32'hEE, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("stray_nowr", {31'd0, bus.fifo_wr}, 32'd0);
        chk("stray_drop", {16'd0, bus.drop_count}, 32'd1);
        idle_cycle();

        // P7: reset mid-capture after 2 words
        drive(32'h70, 1'b1, 1'b0, 2'd0, 1'b0);
        drive(32'h71, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("p7_w1_wr", {31'd0, bus.fifo_wr}, 32'd1);
        snap = ctrl_cnt;
        bus.snk_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("p7_rst_nowr", {31'd0, bus.fifo_wr}, 32'd0);
        chk("p7_rst_drop", {16'd0, bus.drop_count}, 32'd0);
        chk("p7_rst_control", bus.control, 32'd0);
        idle_cycle();
        idle_cycle();
        reset = 1'b1;
        idle_cycle();
        idle_cycle();
        chk("p7_no_ctrl", 32'(ctrl_cnt - snap), 32'd0);

        // P8: first packet after reset, empty=2
        drive(32'h77, 1'b1, 1'b1, 2'd2, 1'b0);
        chk("p8_fifo_in", bus.fifo_in, 32'h77);
        chk("p8_wr_ctrl", {31'd0, bus.wr_ctrl}, 32'd1);
        chk("p8_control", bus.control, 32'h0000_0002);
        chk("p8_begin", bus.pkt_begin, 32'd0);
        chk("p8_end", bus.pkt_end, 32'd4);
        chk("p8_waddr", bus.write_address, 32'h0000_1000);
        idle_cycle();
        pulse_rdy();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pkt_capture.md
# pkt_capture

Upstream stage of the packet write path. Snoops a 32-bit Avalon-ST packet stream and pushes each packet's words into the shared FIFO. Once a packet is closed, it hands the write controller one descriptor (`control`, `pkt_begin`, `pkt_end`, `write_address`) and pulses `wr_ctrl`, then waits for `wr_ctrl_rdy`. It also manages the host ring-buffer offset, so consecutive packets land back-to-back in the mapped buffer.

## Interface
- `BUF_BASE`, default 32'h0000_0000: host byte address of the ring buffer.
- `BUF_SIZE`, default 32'h0001_0000: ring size in bytes, multiple of 4.
- `MAX_PKT_WORDS`, default 16'd512: per-packet word cap; must not exceed FIFO depth.
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low.
- `snk_data` in 32: stream data word.
- `snk_valid` in 1: word valid.
- `snk_sop` in 1: first word of packet.
- `snk_eop` in 1: last word of packet.
- `snk_empty` in 2: unused bytes in the eop word.
- `snk_ready` out 1: constant 1; this is a tap and never backpressures.
- `fifo_full` in 1: FIFO full.
- `fifo_wr` out 1: FIFO write strobe.
- `fifo_in` out 32: FIFO write data.
- `wr_ctrl` out 1: one-cycle start pulse to the write controller.
- `wr_ctrl_rdy` in 1: write controller finished the packet (one-cycle pulse).
- `control` out 32: bits [15:0] byte length, [16] truncated, [23:17] zero, [31:24] sequence number.
- `pkt_begin` out 32: ring offset of the packet start.
- `pkt_end` out 32: `pkt_begin` + 4·words.
- `write_address` out 32: `BUF_BASE` + `pkt_begin`.
- `drop_count` out 16: saturating count of dropped packets.

## Operation
- States:
  - IDLE: wait for `snk_valid` && `snk_sop`; valid words without sop are ignored.
    - On sop, if offset + 4·`MAX_PKT_WORDS` > `BUF_SIZE`, offset wraps to 0 before capture.
    - The sop word is handled exactly like a CAPTURE word.
  - CAPTURE: each valid word with !`fifo_full` and words < `MAX_PKT_WORDS` drives `fifo_wr`=1, `fifo_in`=`snk_data`, and words+1.
    - A valid word that is not written (FIFO full or at the cap) sets truncated.
    - After truncation, no further words are written for this packet.
    - eop ends the packet and moves to ISSUE, or to IDLE with drop_count+1 when words==0.
    - sop without a preceding eop closes the current packet as truncated; the new sop word is discarded and counts as a drop.
  - ISSUE: latch the descriptor, assert `wr_ctrl` for exactly one cycle, then move to WAIT.
  - WAIT: hold the descriptor stable. On `wr_ctrl_rdy`: offset += 4·words, sequence+1, go to IDLE.
- Byte length:
  - If the eop word was written: 4·words − `snk_empty`.
  - Otherwise: 4·words.
- Any sop arriving in ISSUE or WAIT drops that whole packet (drop_count+1); its words are not written.
- Arithmetic:
  - Offset is 32-bit and always a multiple of 4; it never exceeds `BUF_SIZE` − 4·words.
  - drop_count saturates at 16'hFFFF.
  - Sequence number wraps at 8 bits.
- This block never flushes the FIFO. After a reset, the FIFO owner must clear it.

## Timing
- Reset values:
  - IDLE state; offset, words, sequence and truncated = 0.
  - `fifo_wr`=0, `fifo_in`=0, `wr_ctrl`=0.
  - `control`, `pkt_begin`, `pkt_end` = 0.
  - `write_address` = `BUF_BASE`.
  - `drop_count`=0; `snk_ready`=1.
- `fifo_wr`/`fifo_in` are registered: one cycle of latency after the accepted stream word.
- `wr_ctrl` rises the cycle after the eop word is sampled.
  - The last `fifo_wr` and the `wr_ctrl` pulse are in the same cycle.
- Descriptor outputs become valid in the `wr_ctrl` cycle and hold unchanged until the cycle after `wr_ctrl_rdy`. The consumer samples them a cycle late, so holding is mandatory.
- `wr_ctrl_rdy` outside WAIT is ignored.
- sop arriving in the same cycle that `wr_ctrl_rdy` is sampled in WAIT is dropped; sop is accepted only in IDLE.
- Reset mid-packet: immediate return to IDLE; a partial packet is never issued.

## Structure
- `pkt_capture_pkg`: state enum (IDLE, CAPTURE, ISSUE, WAIT); `control` field offsets and widths; `CTRL_TRUNC_BIT`.
- Optional sub-module `ring_offset`: owns the offset register, wrap check and advance, with inputs `start`, `words`, `commit`.

## Test plan
- 3-word packet, `snk_empty`=1, `BUF_BASE`=32'h1000:
  - Three `fifo_wr`; then `wr_ctrl` pulse with `control`=32'h0000_000B, `pkt_begin`=0, `pkt_end`=12, `write_address`=32'h1000.
  - After `wr_ctrl_rdy`, the next packet's `pkt_begin`=12.
- `fifo_full` asserted on word 3 of a 5-word packet:
  - 2 writes; `control`[16]=1, length=8, `pkt_end`=8.
- Single-word packet arrives during WAIT:
  - No `fifo_wr`, `drop_count`=1.
  - The held descriptor is unchanged until `wr_ctrl_rdy`.
- `BUF_SIZE`=32'h100, `MAX_PKT_WORDS`=16, offset=0xC8 at sop:
  - Offset wraps, `pkt_begin`=0, `write_address`=`BUF_BASE`.
- `reset` dropped mid-CAPTURE after 2 words:
  - `fifo_wr`=0 and `wr_ctrl` never pulses.
  - After release, the next packet has `pkt_begin`=0 and sequence 0.
